// File: rtl/sigstat_window.sv
`default_nettype none
// ============================================================================
// Module   : sigstat_window
// Brief    : Measurement sequencer for a signed min/max/count statistics stage.
//            Clears and enables the stage for window_len samples, then latches
//            min, max, peak-to-peak and midpoint results.
// Revision : 1.0 - initial release
// ============================================================================
module sigstat_window #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic [31:0]        window_len,
    output logic               stat_enable,
    output logic               stat_reset,
    output logic [31:0]        stat_limit,
    input  logic [WIDTH-1:0]   stat_min,
    input  logic [WIDTH-1:0]   stat_max,
    input  logic [31:0]        stat_count,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [WIDTH-1:0]   res_min,
    output logic [WIDTH-1:0]   res_max,
    output logic [WIDTH:0]     res_p2p,
    output logic [WIDTH-1:0]   res_mid,
    output logic [31:0]        win_cnt
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_CLEAR = 2'd1;
    localparam logic [1:0] c_ST_RUN   = 2'd2;
    localparam logic [1:0] c_ST_LATCH = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [31:0]      r_len_q;
    logic [31:0]      w_len_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic             w_latch;

    logic             r_stat_enable;
    logic             r_stat_reset;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_res_min;
    logic [WIDTH-1:0] r_res_max;
    logic [WIDTH:0]   r_res_p2p;
    logic [WIDTH-1:0] r_res_mid;
    logic [31:0]      r_win_cnt;

    logic [WIDTH:0]   w_min_ext;
    logic [WIDTH:0]   w_max_ext;
    logic [WIDTH:0]   w_p2p;
    logic [WIDTH-1:0] w_mid;

    // Sign-extended difference always fits in WIDTH+1 bits, so p2p never wraps.
    assign w_min_ext = {stat_min[WIDTH-1], stat_min};
    assign w_max_ext = {stat_max[WIDTH-1], stat_max};
    assign w_p2p     = w_max_ext - w_min_ext;

    // floor((a+b)/2) without a wider adder: halve each operand, then restore
    // the carry that both dropped LSBs would have produced together.
    assign w_mid = WIDTH'($signed(stat_max) >>> 1)
                 + WIDTH'($signed(stat_min) >>> 1)
                 + {{(WIDTH-1){1'b0}}, stat_max[0] & stat_min[0]};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= c_ST_IDLE;
            r_len_q <= 32'd0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_len_q <= w_len_nxt;
            r_err   <= w_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len_q;
        w_err_nxt   = r_err;
        w_latch     = 1'b0;
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        // A zero limit would leave the stats stage unbounded.
                        if (window_len != 32'd0) begin
                            w_len_nxt   = window_len;
                            w_err_nxt   = 1'b0;
                            w_state_nxt = c_ST_CLEAR;
                        end else begin
                            w_err_nxt   = 1'b1;
                        end
                    end
                end
                c_ST_CLEAR: begin
                    w_state_nxt = c_ST_RUN;
                end
                c_ST_RUN: begin
                    if (stat_count == r_len_q) begin
                        w_state_nxt = c_ST_LATCH;
                    end
                end
                c_ST_LATCH: begin
                    w_latch     = 1'b1;
                    w_state_nxt = continuous ? c_ST_CLEAR : c_ST_IDLE;
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they align with the state.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stat_enable <= 1'b0;
            r_stat_reset  <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_res_min     <= '0;
            r_res_max     <= '0;
            r_res_p2p     <= '0;
            r_res_mid     <= '0;
            r_win_cnt     <= 32'd0;
        end else begin
            r_stat_enable <= (w_state_nxt == c_ST_RUN);
            r_stat_reset  <= (w_state_nxt == c_ST_CLEAR);
            r_busy        <= (w_state_nxt != c_ST_IDLE);
            r_done        <= w_latch;
            if (w_latch) begin
                r_res_min <= stat_min;
                r_res_max <= stat_max;
                r_res_p2p <= w_p2p;
                r_res_mid <= w_mid;
                r_win_cnt <= r_win_cnt + 32'd1;
            end
        end
    end

    assign stat_enable = r_stat_enable;
    assign stat_reset  = r_stat_reset;
    assign stat_limit  = r_len_q;
    assign busy        = r_busy;
    assign done        = r_done;
    assign err         = r_err;
    assign res_min     = r_res_min;
    assign res_max     = r_res_max;
    assign res_p2p     = r_res_p2p;
    assign res_mid     = r_res_mid;
    assign win_cnt     = r_win_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sigstat_window.sv
`default_nettype none
// ============================================================================
// Module   : tb_sigstat_window
// Brief    : Randomized self-checking bench for sigstat_window with a simple
//            stats-stage model and a queue-based reference of each window.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sigstat_window;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          resetn;
    logic          start;
    logic          abort;
    logic          continuous;
    logic [31:0]   window_len;
    logic          stat_enable;
    logic          stat_reset;
    logic [31:0]   stat_limit;
    logic [W-1:0]  stat_min;
    logic [W-1:0]  stat_max;
    logic [31:0]   stat_count;
    logic          busy;
    logic          done;
    logic          err;
    logic [W-1:0]  res_min;
    logic [W-1:0]  res_max;
    logic [W:0]    res_p2p;
    logic [W-1:0]  res_mid;
    logic [31:0]   win_cnt;

    logic          s_valid;
    logic [W-1:0]  s_data;

    int n_chk  = 0;
    int n_pass = 0;
    int exp_win = 0;
    int e_min = 0;
    int e_max = 0;
    int pre_q[$];
    int acc[$];

    always #5 clk = ~clk;

    sigstat_window #(.WIDTH(W)) u_dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .window_len (window_len),
        .stat_enable(stat_enable),
        .stat_reset (stat_reset),
        .stat_limit (stat_limit),
        .stat_min   (stat_min),
        .stat_max   (stat_max),
        .stat_count (stat_count),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .res_min    (res_min),
        .res_max    (res_max),
        .res_p2p    (res_p2p),
        .res_mid    (res_mid),
        .win_cnt    (win_cnt)
    );

    // Stats stage: min/max/count update together on an accepted sample.
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            stat_count <= 32'd0;
            stat_min   <= '0;
            stat_max   <= '0;
        end else if (stat_reset) begin
            stat_count <= 32'd0;
            stat_min   <= '0;
            stat_max   <= '0;
        end else if (stat_enable && s_valid && stat_count < stat_limit) begin
            stat_count <= stat_count + 32'd1;
            if (stat_count == 32'd0 || $signed(s_data) < $signed(stat_min)) stat_min <= s_data;
            if (stat_count == 32'd0 || $signed(s_data) > $signed(stat_max)) stat_max <= s_data;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [63:0] u16(input int v);
        logic [15:0] t;
        t = v[15:0];
        return {48'd0, t};
    endfunction

    task automatic do_start(input int len);
        window_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Offer samples while the stage is enabled and still below its limit.
    task automatic feed(input int len, input int nmax);
        int bound;
        int v;
        acc.delete();
        bound = 0;
        while (stat_enable !== 1'b1 && bound < 20) begin
            @(negedge clk);
            bound++;
        end
        chk("enable_up", stat_enable, 1);
        chk("limit", stat_limit, len);
        while (acc.size() < nmax && stat_enable === 1'b1 && bound < 500) begin
            bound++;
            if (stat_count < len && $urandom_range(0, 3) != 0) begin
                if (pre_q.size() > 0) v = pre_q.pop_front();
                else v = int'($urandom_range(0, 65535)) - 32768;
                s_data  = v[W-1:0];
                s_valid = 1'b1;
                @(negedge clk);
                acc.push_back(v);
            end else begin
                s_valid = 1'b0;
                @(negedge clk);
            end
        end
        s_valid = 1'b0;
    endtask

    // Called one half-cycle after the last accepted sample edge.
    task automatic finish_window(input bit cont);
        int mn, mx, sum, mid;
        mn = 0;
        mx = 0;
        if (acc.size() > 0) begin
            mn = acc[0];
            mx = acc[0];
        end
        foreach (acc[i]) begin
            if (acc[i] < mn) mn = acc[i];
            if (acc[i] > mx) mx = acc[i];
        end
        sum = mx + mn;
        mid = (sum >= 0) ? sum / 2 : -((1 - sum) / 2);
        e_min = mn;
        e_max = mx;
        exp_win++;
        chk("done_early0", done, 0);
        @(negedge clk);
        chk("done_early1", done, 0);
        chk("enable_off", stat_enable, 0);
        @(negedge clk);
        chk("done", done, 1);
        chk("res_min", res_min, u16(mn));
        chk("res_max", res_max, u16(mx));
        chk("res_p2p", res_p2p, mx - mn);
        chk("res_mid", res_mid, u16(mid));
        chk("win_cnt", win_cnt, exp_win);
        chk("busy_after", busy, cont);
        chk("rearm_clear", stat_reset, cont);
        @(negedge clk);
        chk("done_pulse", done, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int len;
        resetn = 1'b0; start = 1'b0; abort = 1'b0; continuous = 1'b0;
        window_len = 32'd0; s_valid = 1'b0; s_data = '0;
        #12;
        chk("rst_stat_reset", stat_reset, 1);
        chk("rst_enable", stat_enable, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_limit", stat_limit, 0);
        chk("rst_res", {res_min, res_max, res_p2p, res_mid}, 0);
        chk("rst_win", win_cnt, 0);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        chk("idle_stat_reset", stat_reset, 0);

        // Known window with latency checks
        pre_q = '{100, -50, 7, 300};
        do_start(4);
        chk("clear_reset", stat_reset, 1);
        chk("clear_enable", stat_enable, 0);
        chk("clear_busy", busy, 1);
        @(negedge clk);
        chk("run_enable_lat", stat_enable, 1);
        chk("run_reset", stat_reset, 0);
        feed(4, 4);
        finish_window(0);

        // Extreme values
        pre_q = '{-32768, 32767};
        do_start(2);
        feed(2, 2);
        finish_window(0);

        // Zero length is rejected, then a good start clears err
        do_start(0);
        chk("err_set", err, 1);
        chk("err_busy", busy, 0);
        begin
            bit seen_en;
            seen_en = 1'b0;
            repeat (5) begin
                @(negedge clk);
                if (stat_enable !== 1'b0 || busy !== 1'b0) seen_en = 1'b1;
            end
            chk("err_no_enable", seen_en, 0);
        end
        do_start(3);
        chk("err_clear", err, 0);
        feed(3, 3);
        finish_window(0);

        // Continuous: three windows, the second constant
        continuous = 1'b1;
        pre_q.delete();
        repeat (3) pre_q.push_back(int'($urandom_range(0, 65535)) - 32768);
        repeat (3) pre_q.push_back(5);
        do_start(3);
        feed(3, 3);
        finish_window(1);
        feed(3, 3);
        finish_window(1);
        continuous = 1'b0;
        feed(3, 3);
        finish_window(0);

        // Abort mid-window; a start during RUN must be ignored
        do_start(10);
        feed(10, 4);
        window_len = 3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("ign_limit", stat_limit, 10);
        chk("ign_enable", stat_enable, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_enable", stat_enable, 0);
        begin
            bit seen_done;
            seen_done = done;
            repeat (4) begin
                @(negedge clk);
                if (done !== 1'b0) seen_done = 1'b1;
            end
            chk("abort_no_done", seen_done, 0);
        end
        chk("abort_win", win_cnt, exp_win);
        chk("abort_min", res_min, u16(e_min));
        chk("abort_max", res_max, u16(e_max));

        // start and abort together in IDLE
        window_len = 5;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", busy, 0);
        chk("sa_reset", stat_reset, 0);

        // Random single-shot windows, first one of length 1
        for (int k = 0; k < 6; k++) begin
            len = (k == 0) ? 1 : int'($urandom_range(1, 8));
            do_start(len);
            feed(len, len);
            finish_window(0);
        end

        // Asynchronous reset in the middle of RUN
        do_start(6);
        feed(6, 2);
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("ares_busy", busy, 0);
        chk("ares_enable", stat_enable, 0);
        chk("ares_stat_reset", stat_reset, 1);
        chk("ares_res", {res_min, res_max, res_p2p, res_mid}, 0);
        chk("ares_win", win_cnt, 0);
        exp_win = 0;
        @(posedge clk);
        #1;
        chk("ares_hold", stat_reset, 1);
        @(negedge clk) resetn = 1'b1;
        @(negedge clk);
        do_start(3);
        feed(3, 3);
        finish_window(0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sigstat_window.md
Name: sigstat_window

Overview:
- Measurement sequencer that drives a signed min/max/count statistics stage and consumes its outputs.
- On start it clears the stats stage and enables it for exactly window_len valid samples.
- It then latches min, max, peak-to-peak and midpoint into result registers and signals done.
- Sits between the register/control interface and the stats stage. Supports single-shot and continuous (auto-rearm) measurement.

Parameters:
WIDTH, 32, sample width; two's-complement signed.

Ports:
clk  input  1  system clock
resetn  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin a window; ignored while busy=1
abort  input  1  level/pulse; terminates any window, returns to IDLE, no result update
continuous  input  1  when 1, rearm automatically after each completed window
window_len  input  32  samples per window; sampled into len_q on accepted start
stat_enable  output  1  enable to stats stage
stat_reset  output  1  synchronous clear to stats stage
stat_limit  output  32  limit to stats stage (= len_q)
stat_min  input  WIDTH  stats stage running minimum (signed)
stat_max  input  WIDTH  stats stage running maximum (signed)
stat_count  input  32  stats stage accepted-sample count
busy  output  1  high in any state other than IDLE
done  output  1  one-cycle pulse when results update
err  output  1  sticky: start with window_len==0; cleared by next accepted start
res_min  output  WIDTH  latched window minimum
res_max  output  WIDTH  latched window maximum
res_p2p  output  WIDTH+1  latched res_max - res_min, unsigned
res_mid  output  WIDTH  latched floor((res_max + res_min)/2), signed
win_cnt  output  32  completed windows since reset; wraps at 2^32

Behaviour:
- Reset (resetn=0, asynchronous):
  - State IDLE, len_q=0.
  - All outputs 0 except stat_reset=1.
  - Registered FSM; all outputs are registered.
- States:
  - IDLE: stat_enable=0, stat_reset=0.
    - start=1 and window_len!=0: len_q<=window_len, err<=0 -> CLEAR.
    - start=1 and window_len==0: err<=1, stay IDLE. A zero limit would make the stats stage unbounded, so it is never issued.
  - CLEAR: stat_reset=1, stat_enable=0 for exactly one cycle -> RUN.
  - RUN: stat_enable=1, stat_limit=len_q.
    - When stat_count==len_q: stat_enable<=0 -> LATCH.
    - The stats stage updates min/max on the same edge as count, so values are final when equality is seen.
  - LATCH (one cycle):
    - res_min<=stat_min, res_max<=stat_max.
    - res_p2p<=sext(stat_max)-sext(stat_min) in WIDTH+1 bits.
    - res_mid<=(sext(stat_max)+sext(stat_min))>>>1, truncated to WIDTH. Arithmetic shift, rounds toward -inf.
    - done<=1 for this cycle, win_cnt<=win_cnt+1.
    - Next state: CLEAR if continuous=1, else IDLE.
- Latency: start to first stat_enable=1 is 2 cycles.
  - Last accepted sample edge to done=1 is 2 cycles.
  - Continuous gap: 2 idle cycles (LATCH, CLEAR); samples in the gap are not counted.
- abort has priority in every state:
  - Next state IDLE, stat_enable<=0, no done.
  - res_* and win_cnt unchanged; busy drops next cycle.
- Other boundaries:
  - start while busy: ignored.
  - window_len changes mid-window: ignored (len_q used).
  - continuous sampled only in LATCH.
  - start and abort in the same cycle in IDLE: abort wins; stays IDLE.
  - window_len=1: one sample, res_min=res_max=sample, res_p2p=0.
  - res_p2p max value is 2^WIDTH-1 (e.g. min=-2^(WIDTH-1), max=2^(WIDTH-1)-1). It never overflows.
  - resetn asserted mid-window: immediate IDLE, results cleared to 0.

Test Plan:
- WIDTH=16, window_len=4, start; samples 100,-50,7,300 -> done 2 cycles after 4th sample; res_min=-50, res_max=300, res_p2p=350, res_mid=125, win_cnt=1, busy=0 after.
- WIDTH=16, window_len=2; samples -32768, 32767 -> res_p2p=65535, res_mid=-1.
- window_len=0, start -> err=1, busy stays 0, stat_enable never asserted. Then window_len=3 and start -> err=0, normal run.
- continuous=1, window_len=3; 9 samples spaced to skip the 2-cycle gaps -> three done pulses, win_cnt=3. Each window's result is independent: window 2 samples 5,5,5 give res_p2p=0.
- window_len=10, abort after 4 samples -> IDLE next cycle, no done, res_* and win_cnt keep prior values. Also: start during RUN is ignored and window length is unchanged.
- resetn low for 1 cycle mid-RUN (asynchronous, between clock edges) -> outputs zero immediately, stat_reset=1 while held. After release, start works normally.
